branch_seq: RTL and testbench
=============================

Name: branch_seq

Overview:
- Control-transfer sequencer for the multicycle CPU; the initiator side of the branch/PC-write-enable mux.
- Main control FSM hands it an instruction (beq/bne/ble/bgt/j/jal/jr) with a start pulse.
- It drives branch_ctrl, PCWrite, PCWriteCond, pc_source, ALU source/op selects and the $31 link write over several cycles, then returns done.
- The existing PC-write-enable mux combines PCWrite/PCWriteCond/branch_ctrl with the ALU gt/eq flags.

Parameters:
- OP_W, 6, opcode and funct field width.
- LINK_REG, 31, register index written by jal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from main control; sampled only in IDLE.
- opcode  in  OP_W  instruction opcode, captured when start is accepted.
- funct  in  OP_W  instruction funct, captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- illegal  out  1  one-cycle pulse together with done when the opcode is unsupported.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load; qualified downstream by branch_ctrl and gt/eq.
- branch_ctrl  out  2  condition select: 00 gt (bgt), 01 ~gt (ble), 10 ~eq (bne), 11 eq (beq).
- pc_source  out  2  PC input select: 00 ALU result, 01 ALUOut, 10 {PC[31:28],imm26,00}, 11 reg A.
- alu_src_a  out  1  ALU A select: 0 PC, 1 reg A.
- alu_src_b  out  2  ALU B select: 00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- alu_op  out  3  ALU operation: 000 load A, 001 add, 010 sub.
- alu_out_load  out  1  ALUOut register load enable.
- reg_write  out  1  register-file write enable.
- link_dst  out  5  register-file write address; LINK_REG when reg_write is high, else 0.

Behaviour:
- All outputs are a Moore decode of the state register. Reset drives state to IDLE asynchronously, which gives all outputs 0 and pc_source=00.
- Supported decode: opcode 0x04 beq, 0x05 bne, 0x06 ble, 0x07 bgt, 0x02 j, 0x03 jal, 0x00 with funct 0x08 jr. Everything else is illegal.
- States and transitions:
  - IDLE: waits for start. On start, captures opcode/funct and branches by class: branch to BR_ADDR, j to J_WRITE, jal to JAL_LINK, jr to JR_WRITE, illegal to FIN with the illegal flag set.
  - BR_ADDR: alu_src_a=0, alu_src_b=11, alu_op=001, alu_out_load=1 (computes PC+offset<<2). Goes to BR_CMP.
  - BR_CMP: alu_src_a=1, alu_src_b=00, alu_op=010, PCWriteCond=1, pc_source=01, branch_ctrl from the captured opcode (bgt 00, ble 01, bne 10, beq 11). Goes to FIN.
  - JAL_LINK: reg_write=1, link_dst=LINK_REG, alu_src_a=0, alu_op=000 (PC already holds PC+4). Goes to J_WRITE.
  - J_WRITE: PCWrite=1, pc_source=10. Goes to FIN.
  - JR_WRITE: PCWrite=1, pc_source=11. Goes to FIN.
  - FIN: done=1; illegal=1 if flagged. Goes to IDLE.
- Latency from the start edge to the done cycle: branch 3, j 2, jal 3, jr 2, illegal 1. The next start is accepted in the cycle after done.
- PCWrite and PCWriteCond are never high in the same cycle. Neither is ever high in IDLE or FIN.
- start while busy is ignored and not queued. Changes on opcode/funct after capture have no effect.
- Reset asserted mid-sequence: all write enables drop immediately (asynchronously) and no done is issued. After reset release the block sits in IDLE.

Decomposition:
- Shared constants include file holds:
  - opcode/funct values;
  - the state encodings (3-bit);
  - pc_source, alu_src_b, alu_op and branch_ctrl encodings.
- The main control FSM reuses the same file.
- One sub-module: branch_seq_decode, purely combinational. It maps opcode/funct to an instruction class {BR, J, JAL, JR, ILL} and a 2-bit cond code.
- The FSM stays in branch_seq.

Test Plan:
- beq (opcode 0x04), start pulse:
  - cycle +1: alu_out_load=1, alu_src_b=11;
  - cycle +2: PCWriteCond=1, branch_ctrl=11, pc_source=01;
  - cycle +3: done=1;
  - PCWrite stays 0 throughout.
- bgt (0x07) and ble (0x06) -> BR_CMP cycle shows branch_ctrl=00 and 01 respectively. bne (0x05) -> 10.
- jal (0x03):
  - cycle +1: reg_write=1, link_dst=31;
  - cycle +2: PCWrite=1, pc_source=10;
  - cycle +3: done=1.
- jr (opcode 0x00, funct 0x08):
  - cycle +1: PCWrite=1, pc_source=11;
  - cycle +2: done=1.
- Illegal inputs (opcode 0x2B, then opcode 0x00 with funct 0x20) -> cycle +1 shows done=1 and illegal=1; all write enables stay 0.
- Start pulsed while in BR_CMP -> ignored, exactly one done. Reset driven low during J_WRITE -> PCWrite falls before the next clock edge and done is never asserted.

Source files
------------

// File: rtl/branch_seq_pkg.sv
// Shared encodings for the control-transfer sequencer and the main control FSM.
`default_nettype none

package branch_seq_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_BLE   = 6'h06;
  localparam logic [5:0] OPC_BGT   = 6'h07;
  localparam logic [5:0] FN_JR     = 6'h08;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BR_ADDR  = 3'd1,
    S_BR_CMP   = 3'd2,
    S_JAL_LINK = 3'd3,
    S_J_WRITE  = 3'd4,
    S_JR_WRITE = 3'd5,
    S_FIN      = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_BR  = 3'd0,
    CLS_J   = 3'd1,
    CLS_JAL = 3'd2,
    CLS_JR  = 3'd3,
    CLS_ILL = 3'd4
  } cls_e;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [2:0] ALUOP_PASSA = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SUB   = 3'b010;

  localparam logic [1:0] BC_GT  = 2'b00;
  localparam logic [1:0] BC_NGT = 2'b01;
  localparam logic [1:0] BC_NEQ = 2'b10;
  localparam logic [1:0] BC_EQ  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/branch_seq_decode.sv
// Combinational opcode/funct classifier: instruction class plus branch condition code.
`default_nettype none

module branch_seq_decode
  import branch_seq_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode_i,
  input  logic [OP_W-1:0] funct_i,
  output cls_e            cls_o,
  output logic [1:0]      cond_o
);

  always_comb begin
    cls_o  = CLS_ILL;
    cond_o = BC_GT;
    case (opcode_i)
      OP_W'(OPC_BEQ):   begin cls_o = CLS_BR; cond_o = BC_EQ;  end
      OP_W'(OPC_BNE):   begin cls_o = CLS_BR; cond_o = BC_NEQ; end
      OP_W'(OPC_BLE):   begin cls_o = CLS_BR; cond_o = BC_NGT; end
      OP_W'(OPC_BGT):   begin cls_o = CLS_BR; cond_o = BC_GT;  end
      OP_W'(OPC_J):     cls_o = CLS_J;
      OP_W'(OPC_JAL):   cls_o = CLS_JAL;
      OP_W'(OPC_RTYPE): cls_o = (funct_i == OP_W'(FN_JR)) ? CLS_JR : CLS_ILL;
      default:          cls_o = CLS_ILL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_seq.sv
// Multicycle control-transfer sequencer: drives PC-write, ALU and link controls, then pulses done.
`default_nettype none

module branch_seq
  import branch_seq_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic [1:0]      branch_ctrl,
  output logic [1:0]      pc_source,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic            alu_out_load,
  output logic            reg_write,
  output logic [4:0]      link_dst
);

  state_e     state_q, state_d;
  logic [1:0] cond_q, cond_d;
  logic       ill_q, ill_d;
  cls_e       dec_cls;
  logic [1:0] dec_cond;

  branch_seq_decode #(.OP_W(OP_W)) u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (dec_cls),
    .cond_o   (dec_cond)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cond_q  <= BC_GT;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      ill_q   <= ill_d;
    end
  end

  // Decoded operands are captured only on an accepted start; later input changes are ignored.
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cond_d = dec_cond;
          ill_d  = 1'b0;
          case (dec_cls)
            CLS_BR:  state_d = S_BR_ADDR;
            CLS_J:   state_d = S_J_WRITE;
            CLS_JAL: state_d = S_JAL_LINK;
            CLS_JR:  state_d = S_JR_WRITE;
            default: begin
              state_d = S_FIN;
              ill_d   = 1'b1;
            end
          endcase
        end
      end
      S_BR_ADDR:  state_d = S_BR_CMP;
      S_BR_CMP:   state_d = S_FIN;
      S_JAL_LINK: state_d = S_J_WRITE;
      S_J_WRITE:  state_d = S_FIN;
      S_JR_WRITE: state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        ill_d   = 1'b0;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    illegal      = 1'b0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    branch_ctrl  = BC_GT;
    pc_source    = PCS_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REGB;
    alu_op       = ALUOP_PASSA;
    alu_out_load = 1'b0;
    reg_write    = 1'b0;
    link_dst     = 5'd0;
    case (state_q)
      S_BR_ADDR: begin
        alu_src_b    = SRCB_SEXT_SH;
        alu_op       = ALUOP_ADD;
        alu_out_load = 1'b1;
      end
      S_BR_CMP: begin
        alu_src_a   = 1'b1;
        alu_op      = ALUOP_SUB;
        PCWriteCond = 1'b1;
        pc_source   = PCS_ALUOUT;
        branch_ctrl = cond_q;
      end
      // PC already holds PC+4 here, so passing A through links the return address.
      S_JAL_LINK: begin
        reg_write = 1'b1;
        link_dst  = 5'(LINK_REG);
      end
      S_J_WRITE: begin
        PCWrite   = 1'b1;
        pc_source = PCS_JUMP;
      end
      S_JR_WRITE: begin
        PCWrite   = 1'b1;
        pc_source = PCS_REGA;
      end
      S_FIN: begin
        done    = 1'b1;
        illegal = ill_q;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: cycle-level reference model plus directed literal checks.
`default_nettype none

module tb_branch_seq;

  typedef struct packed {
    logic       busy, done, ill, pcw, pcwc;
    logic [1:0] bc, pcs;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aop;
    logic       aol, rw;
    logic [4:0] ld;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       busy, done, illegal, PCWrite, PCWriteCond, alu_src_a, alu_out_load, reg_write;
  logic [1:0] branch_ctrl, pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [4:0] link_dst;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  ov_t exp_q[$];
  ov_t cur;
  ov_t dut_v;

  branch_seq #(.OP_W(6), .LINK_REG(31)) dut (
    .clk(clk), .reset(rst_n), .start(start), .opcode(opcode), .funct(funct),
    .busy(busy), .done(done), .illegal(illegal), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .branch_ctrl(branch_ctrl), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_out_load(alu_out_load), .reg_write(reg_write), .link_dst(link_dst)
  );

  always #5 clk = ~clk;

  assign dut_v = '{busy, done, illegal, PCWrite, PCWriteCond, branch_ctrl, pc_source,
                   alu_src_a, alu_src_b, alu_op, alu_out_load, reg_write, link_dst};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Expected per-cycle output sequence for one instruction, straight from the instruction rules.
  task automatic push_seq(input logic [5:0] op, input logic [5:0] fn);
    ov_t v;
    ov_t fin;
    fin = '0; fin.busy = 1; fin.done = 1;
    case (op)
      6'h04, 6'h05, 6'h06, 6'h07: begin
        v = '0; v.busy = 1; v.srcb = 2'b11; v.aop = 3'b001; v.aol = 1;
        exp_q.push_back(v);
        v = '0; v.busy = 1; v.pcwc = 1; v.pcs = 2'b01; v.srca = 1; v.aop = 3'b010;
        v.bc = (op == 6'h07) ? 2'b00 : (op == 6'h06) ? 2'b01 : (op == 6'h05) ? 2'b10 : 2'b11;
        exp_q.push_back(v);
      end
      6'h02, 6'h03: begin
        if (op == 6'h03) begin
          v = '0; v.busy = 1; v.rw = 1; v.ld = 5'd31;
          exp_q.push_back(v);
        end
        v = '0; v.busy = 1; v.pcw = 1; v.pcs = 2'b10;
        exp_q.push_back(v);
      end
      default: begin
        if (op == 6'h00 && fn == 6'h08) begin
          v = '0; v.busy = 1; v.pcw = 1; v.pcs = 2'b11;
          exp_q.push_back(v);
        end else begin
          fin.ill = 1;
        end
      end
    endcase
    exp_q.push_back(fin);
  endtask

  // Model: cur holds the expected outputs for the cycle currently in progress.
  initial begin
    cur = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        cur = '0;
      end else begin
        if (!cur.busy && start) push_seq(opcode, funct);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : ov_t'('0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_total++;
        if (dut_v === cur) n_pass++;
        else $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, dut_v, cur);
      end
    end
  end

  task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input int lat,
                        input bit ill, input bit chk_bc, input logic [1:0] bc, input string nm);
    int n;
    bit seen;
    logic [1:0] bc_seen;
    @(posedge clk); #1 start = 1; opcode = op; funct = fn;
    @(posedge clk); #1 start = 0; opcode = 6'($urandom); funct = 6'($urandom);
    n = 1; seen = 0; bc_seen = 2'bxx;
    while (!seen && n <= 8) begin
      if (PCWriteCond) bc_seen = branch_ctrl;
      if (done) seen = 1;
      else begin @(posedge clk); #1 n++; end
    end
    check({nm, "_latency"}, n, lat);
    check({nm, "_illegal"}, {31'd0, illegal}, {31'd0, ill});
    if (chk_bc) check({nm, "_branch_ctrl"}, {30'd0, bc_seen}, {30'd0, bc});
  endtask

  initial begin
    int ndone;
    #1 rst_n = 0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("reset_state", {10'd0, dut_v}, 32'd0);

    // beq, checked cycle by cycle
    @(posedge clk); #1 start = 1; opcode = 6'h04; funct = 6'h00;
    @(posedge clk); #1 start = 0; opcode = 6'h3f;
    check("beq_c1_aluout_load", alu_out_load, 1);
    check("beq_c1_alu_src_b", alu_src_b, 2'b11);
    check("beq_c1_pcwrite", PCWrite, 0);
    @(posedge clk); #1;
    check("beq_c2_pcwritecond", PCWriteCond, 1);
    check("beq_c2_branch_ctrl", branch_ctrl, 2'b11);
    check("beq_c2_pc_source", pc_source, 2'b01);
    check("beq_c2_pcwrite", PCWrite, 0);
    @(posedge clk); #1;
    check("beq_c3_done", done, 1);
    check("beq_c3_pcwrite", PCWrite, 0);

    // jal
    @(posedge clk); #1 start = 1; opcode = 6'h03;
    @(posedge clk); #1 start = 0; opcode = 6'h00;
    check("jal_c1_reg_write", reg_write, 1);
    check("jal_c1_link_dst", link_dst, 5'd31);
    @(posedge clk); #1;
    check("jal_c2_pcwrite", PCWrite, 1);
    check("jal_c2_pc_source", pc_source, 2'b10);
    @(posedge clk); #1;
    check("jal_c3_done", done, 1);

    // jr
    @(posedge clk); #1 start = 1; opcode = 6'h00; funct = 6'h08;
    @(posedge clk); #1 start = 0; funct = 6'h20;
    check("jr_c1_pcwrite", PCWrite, 1);
    check("jr_c1_pc_source", pc_source, 2'b11);
    @(posedge clk); #1;
    check("jr_c2_done", done, 1);

    run_op(6'h07, 6'h00, 3, 0, 1, 2'b00, "bgt");
    run_op(6'h06, 6'h00, 3, 0, 1, 2'b01, "ble");
    run_op(6'h05, 6'h00, 3, 0, 1, 2'b10, "bne");
    run_op(6'h02, 6'h00, 2, 0, 0, 2'b00, "j");
    run_op(6'h2B, 6'h00, 1, 1, 0, 2'b00, "ill_sw");
    run_op(6'h00, 6'h20, 1, 1, 0, 2'b00, "ill_add");
    run_op(6'h04, 6'h00, 3, 0, 1, 2'b11, "beq_after_ill");

    // stray start during BR_CMP must be ignored
    @(posedge clk); #1 start = 1; opcode = 6'h05;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 start = 1; opcode = 6'h03;
    check("stray_in_brcmp", PCWriteCond, 1);
    @(posedge clk); #1 start = 0;
    ndone = int'(done);
    repeat (6) begin @(posedge clk); #1 ndone += int'(done); end
    check("stray_done_count", ndone, 1);

    // reset during J_WRITE
    @(posedge clk); #1 start = 1; opcode = 6'h02;
    @(posedge clk); #1 start = 0;
    check("rst_jwrite_pcwrite", PCWrite, 1);
    #2 rst_n = 0;
    #1;
    check("rst_async_pcwrite", PCWrite, 0);
    check("rst_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    ndone = 0;
    repeat (5) begin @(posedge clk); #1 ndone += int'(done); end
    check("rst_no_done", ndone, 0);
    check("rst_idle", busy, 0);

    run_op(6'h00, 6'h08, 2, 0, 0, 2'b00, "jr_after_rst");

    repeat (2) @(posedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
